// File: rtl/div_unit_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | div_unit_pkg : shared control codes, FSM states, helpers for divider  |
// | Revision     : 1.0                                                    |
// +-----------------------------------------------------------------------+
package div_unit_pkg;

  localparam int unsigned DIV_W = 32;

  // ALU control codes that start a division
  localparam logic [4:0] DIV_CONTROL  = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL = 5'b11011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v, input logic is_signed);
    return (is_signed && v[DIV_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | div_unit_if : EX-stage operand/op inputs and HI/LO result outputs     |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             annul;
  logic             stall;
  logic             valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output op, a, b, annul, input stall, valid, hi, lo);
  modport slave  (input op, a, b, annul, output stall, valid, hi, lo);
endinterface
`default_nettype wire

// File: rtl/div_unit_step.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | div_step : one combinational radix-2 restoring division iteration     |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;
  logic           w_unused_msb;

  // rem < divisor always holds, so the top bit never carries information in
  assign w_unused_msb = rem_i[WIDTH];

  always_comb begin
    w_shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
    w_diff    = w_shifted - {1'b0, dvsr_i};
    if (!w_diff[WIDTH]) begin
      rem_o = w_diff;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = w_shifted;
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | div_unit : multi-cycle 32-bit DIV/DIVU unit with pipeline stall       |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic      clk,
  input  logic      resetn,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             signed_q, signed_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             w_div_op;
  logic [WIDTH:0]   w_step_rem;
  logic [WIDTH-1:0] w_step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (w_step_rem),
    .quo_o  (w_step_quo)
  );

  assign w_div_op = (bus.op == DIV_CONTROL) || (bus.op == DIVU_CONTROL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      signed_q <= 1'b0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      signed_q <= signed_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    signed_d = signed_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      DIV_IDLE: begin
        if (w_div_op && !bus.annul) begin
          signed_d = (bus.op == DIV_CONTROL);
          qsign_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          rsign_d  = bus.a[WIDTH-1];
          quo_d    = abs_val(bus.a, signed_d);
          dvsr_d   = abs_val(bus.b, signed_d);
          rem_d    = '0;
          cnt_d    = '0;
          if (bus.b == '0) begin
            lo_d    = '1;
            hi_d    = bus.a;
            state_d = DIV_DONE;
          end else begin
            state_d = DIV_BUSY;
          end
        end
      end

      DIV_BUSY: begin
        if (bus.annul) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = w_step_rem;
          quo_d = w_step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            // Magnitudes stay unsigned so 0x80000000 / -1 yields 0x80000000
            lo_d    = (signed_q && qsign_q) ? -w_step_quo : w_step_quo;
            hi_d    = (signed_q && rsign_q) ? -w_step_rem[WIDTH-1:0] : w_step_rem[WIDTH-1:0];
            state_d = DIV_DONE;
          end
        end
      end

      DIV_DONE: state_d = DIV_IDLE;

      default: state_d = DIV_IDLE;
    endcase
  end

  // Held low during reset so a pending op cannot stall a pipeline being reset
  assign bus.stall = resetn & (((state_q == DIV_IDLE) & w_div_op & ~bus.annul)
                             | ((state_q == DIV_BUSY) & ~bus.annul));
  assign bus.valid = (state_q == DIV_DONE) & ~bus.annul;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_div_unit : directed self-checking bench for div_unit               |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
module tb_div_unit;
  import div_unit_pkg::*;

  localparam logic [4:0] NOP = 5'd0;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Entered at posedge+1 of cycle 0; returns at posedge+1 of the cycle after valid, op still held.
  task automatic do_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] rhi, output logic [31:0] rlo,
                        output bit stall_ok);
    lat      = -1;
    rhi      = 'x;
    rlo      = 'x;
    stall_ok = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.annul = 1'b0;
    #1;
    if (bus.stall !== 1'b1) stall_ok = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #2;
      if (bus.valid === 1'b1) begin
        lat = n;
        rhi = bus.hi;
        rlo = bus.lo;
        if (bus.stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.op = NOP; bus.a = '0; bus.b = '0; bus.annul = 1'b0;
    #2;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
    #10 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  // Consecutive vectors run back-to-back: each new op appears on the cycle after DONE.
  task automatic test_divides();
    logic [4:0]  v_op [6];
    logic [31:0] v_a  [6];
    logic [31:0] v_b  [6];
    logic [31:0] v_lo [6];
    logic [31:0] v_hi [6];
    int lat; logic [31:0] rhi, rlo; bit sok;
    v_op = '{DIV_CONTROL, DIV_CONTROL, DIV_CONTROL, DIVU_CONTROL, DIV_CONTROL, DIVU_CONTROL};
    v_a  = '{32'd7, 32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1000};
    v_b  = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'h10, 32'h10, 32'd1000};
    v_lo = '{32'd3, 32'hFFFFFFFD, 32'h80000000, 32'h0FFFFFFF, 32'h0, 32'd1};
    v_hi = '{32'd1, 32'hFFFFFFFF, 32'h0, 32'hF, 32'hFFFFFFFF, 32'd0};
    for (int i = 0; i < 6; i++) begin
      do_div(v_op[i], v_a[i], v_b[i], lat, rhi, rlo, sok);
      total++; if (lat != 33) begin bad++; $display("FAIL div%0d_latency got=%0d want=33", i, lat); end
      total++; if (rlo !== v_lo[i]) begin bad++; $display("FAIL div%0d_lo got=%h want=%h", i, rlo, v_lo[i]); end
      total++; if (rhi !== v_hi[i]) begin bad++; $display("FAIL div%0d_hi got=%h want=%h", i, rhi, v_hi[i]); end
      total++; if (sok !== 1'b1) begin bad++; $display("FAIL div%0d_stall got=%b want=1", i, sok); end
    end
    bus.op = NOP;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL done_no_restart got=%b want=0", bus.stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] rhi, rlo; bit sok;
    do_div(DIV_CONTROL, 32'h12345678, 32'h0, lat, rhi, rlo, sok);
    bus.op = NOP;
    total++; if (lat != 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", lat); end
    total++; if (rlo !== 32'hFFFFFFFF) begin bad++; $display("FAIL dz_lo got=%h want=ffffffff", rlo); end
    total++; if (rhi !== 32'h12345678) begin bad++; $display("FAIL dz_hi got=%h want=12345678", rhi); end
    total++; if (sok !== 1'b1) begin bad++; $display("FAIL dz_stall got=%b want=1", sok); end
    @(posedge clk); #1;
  endtask

  task automatic test_annul();
    int lat; logic [31:0] rhi, rlo; bit sok, saw_valid;
    bus.op = DIV_CONTROL; bus.a = 32'd100; bus.b = 32'd7; bus.annul = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.annul = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL annul_busy_stall got=%b want=0", bus.stall); end
    @(posedge clk); #1;
    bus.annul = 1'b0; bus.op = NOP;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL annul_idle_c11 got=%b want=0", bus.stall); end
    saw_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (bus.valid !== 1'b0) saw_valid = 1'b1;
    end
    total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL annul_no_valid got=%b want=0", saw_valid); end
    total++; if (bus.hi !== 32'h12345678) begin bad++; $display("FAIL annul_hi_hold got=%h want=12345678", bus.hi); end
    total++; if (bus.lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL annul_lo_hold got=%h want=ffffffff", bus.lo); end
    // annul while IDLE must block the start
    bus.op = DIV_CONTROL; bus.annul = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL annul_start_stall got=%b want=0", bus.stall); end
    @(posedge clk); #1;
    bus.op = NOP; bus.annul = 1'b0;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL annul_start_blocked got=%b want=0", bus.stall); end
    @(posedge clk); #1;
    do_div(DIV_CONTROL, 32'd100, 32'd7, lat, rhi, rlo, sok);
    bus.op = NOP;
    total++; if (lat != 33) begin bad++; $display("FAIL post_annul_latency got=%0d want=33", lat); end
    total++; if (rlo !== 32'd14) begin bad++; $display("FAIL post_annul_lo got=%h want=0000000e", rlo); end
    total++; if (rhi !== 32'd2) begin bad++; $display("FAIL post_annul_hi got=%h want=00000002", rhi); end
    @(posedge clk); #1;
  endtask

  task automatic test_annul_done();
    bus.op = DIVU_CONTROL; bus.a = 32'd9; bus.b = 32'd3; bus.annul = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL done_valid got=%b want=1", bus.valid); end
    bus.annul = 1'b1;
    #1;
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL done_annul_valid got=%b want=0", bus.valid); end
    total++; if (bus.lo !== 32'd3) begin bad++; $display("FAIL done_annul_lo got=%h want=00000003", bus.lo); end
    bus.annul = 1'b0; bus.op = NOP;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rhi, rlo; bit sok;
    bus.op = DIVU_CONTROL; bus.a = 32'd50; bus.b = 32'd5; bus.annul = 1'b0;
    repeat (15) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b want=0", bus.stall); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", bus.valid); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL rst_mid_hi got=%h want=0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL rst_mid_lo got=%h want=0", bus.lo); end
    #1 bus.op = NOP;
    @(posedge clk); #3 resetn = 1'b1;
    @(posedge clk); #1;
    do_div(DIVU_CONTROL, 32'd9, 32'd3, lat, rhi, rlo, sok);
    bus.op = NOP;
    total++; if (lat != 33) begin bad++; $display("FAIL rst_div_latency got=%0d want=33", lat); end
    total++; if (rlo !== 32'd3) begin bad++; $display("FAIL rst_div_lo got=%h want=00000003", rlo); end
    total++; if (rhi !== 32'd0) begin bad++; $display("FAIL rst_div_hi got=%h want=0", rhi); end
    total++; if (sok !== 1'b1) begin bad++; $display("FAIL rst_div_stall got=%b want=1", sok); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_divides();
    test_div_zero();
    test_annul();
    test_annul_done();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
